// File: rtl/cdc_event_sync.sv
// Purpose : multi-channel async-level synchroniser with glitch filter, edge detect,
//           per-channel edge qualification, pending/ack handshake, saturating counters.
// Latency : step sampled at edge k -> pulse in the cycle after edge k+SYNC_STAGES+FILT_LEN.
// Backpr. : none; events are never stalled.
//           An event arriving while pending is still set raises a sticky overflow flag.
// Ports   : out_clk/rst (async, active-low) | async_in, edge_mode, evt_ack, cnt_clr in |
//           level_out, rise/fall/evt_pulse, evt_pending, overflow, evt_cnt out.
module cdc_event_sync #(
   parameter int CH          = 4,
   parameter int SYNC_STAGES = 2,   // must be >= 2
   parameter int FILT_LEN    = 0,
   parameter int CNT_W       = 8
) (
   input  logic                out_clk,
   input  logic                rst,
   input  logic [CH-1:0]       async_in,
   input  logic [2*CH-1:0]     edge_mode,
   input  logic [CH-1:0]       evt_ack,
   input  logic                cnt_clr,
   output logic [CH-1:0]       level_out,
   output logic [CH-1:0]       rise_pulse,
   output logic [CH-1:0]       fall_pulse,
   output logic [CH-1:0]       evt_pulse,
   output logic [CH-1:0]       evt_pending,
   output logic [CH-1:0]       overflow,
   output logic [CH*CNT_W-1:0] evt_cnt
);

   localparam int FW = (FILT_LEN > 0) ? $clog2(FILT_LEN + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   sync_out;
      logic                   level_q;
      logic                   prev_q;
      logic                   pend_q;
      logic                   ovf_q;
      logic [CNT_W-1:0]       cnt_q;
      logic                   rise;
      logic                   fall;
      logic                   evt;

      // Plain shift chain: nothing may sit between synchroniser stages.
      always_ff @(posedge out_clk or negedge rst) begin
         if (!rst) sync_q <= '0;
         else      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in[i]};
      end
      assign sync_out = sync_q[SYNC_STAGES-1];

      if (FILT_LEN == 0) begin : g_nofilt
         always_ff @(posedge out_clk or negedge rst) begin
            if (!rst) level_q <= 1'b0;
            else      level_q <= sync_out;
         end
      end else begin : g_filt
         logic [FW-1:0] filt_cnt;
         // The new level must differ on FILT_LEN+1 consecutive edges: the counter
         // counts mismatching edges and the level flips on the one after it hits FILT_LEN.
         always_ff @(posedge out_clk or negedge rst) begin
            if (!rst) begin
               level_q  <= 1'b0;
               filt_cnt <= '0;
            end else if (sync_out == level_q) begin
               filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT_LEN)) begin
               level_q  <= sync_out;
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + FW'(1);
            end
         end
      end

      // Edges come from registers only, so edge_mode changes cannot fabricate events.
      assign rise = level_q & ~prev_q;
      assign fall = ~level_q & prev_q;
      assign evt  = (rise & edge_mode[2*i]) | (fall & edge_mode[2*i+1]);

      always_ff @(posedge out_clk or negedge rst) begin
         if (!rst) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
         end else begin
            prev_q <= level_q;

            // A new event wins over an ack arriving in the same cycle.
            if (evt)             pend_q <= 1'b1;
            else if (evt_ack[i]) pend_q <= 1'b0;

            // Setting takes priority over clearing so a lost event is never hidden.
            if (evt && pend_q && !evt_ack[i]) ovf_q <= 1'b1;
            else if (cnt_clr)                 ovf_q <= 1'b0;

            if (cnt_clr)                   cnt_q <= evt ? CNT_W'(1) : '0;
            else if (evt && cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
         end
      end

      assign level_out[i]              = level_q;
      assign rise_pulse[i]             = rise;
      assign fall_pulse[i]             = fall;
      assign evt_pulse[i]              = evt;
      assign evt_pending[i]            = pend_q;
      assign overflow[i]               = ovf_q;
      assign evt_cnt[i*CNT_W +: CNT_W] = cnt_q;
   end

endmodule

// File: tb/tb_cdc_event_sync.sv
// Bench for cdc_event_sync: instance a (FILT_LEN=0, CNT_W=8) and instance b
// (FILT_LEN=3, CNT_W=4) share control inputs; each scenario starts from reset.
module tb_cdc_event_sync;

   logic        out_clk = 1'b0;
   logic        rst;
   logic [3:0]  async_a, async_b;
   logic [7:0]  edge_mode;
   logic [3:0]  evt_ack;
   logic        cnt_clr;

   logic [3:0]  level_a, rise_a, fall_a, evt_a, pend_a, ovf_a;
   logic [31:0] cnt_a;
   logic [3:0]  level_b, rise_b, fall_b, evt_b, pend_b, ovf_b;
   logic [15:0] cnt_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 out_clk = ~out_clk;

   cdc_event_sync #(.CH(4), .SYNC_STAGES(2), .FILT_LEN(0), .CNT_W(8)) dut_a (
      .out_clk(out_clk), .rst(rst), .async_in(async_a), .edge_mode(edge_mode),
      .evt_ack(evt_ack), .cnt_clr(cnt_clr), .level_out(level_a), .rise_pulse(rise_a),
      .fall_pulse(fall_a), .evt_pulse(evt_a), .evt_pending(pend_a), .overflow(ovf_a),
      .evt_cnt(cnt_a));

   cdc_event_sync #(.CH(4), .SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(4)) dut_b (
      .out_clk(out_clk), .rst(rst), .async_in(async_b), .edge_mode(edge_mode),
      .evt_ack(evt_ack), .cnt_clr(cnt_clr), .level_out(level_b), .rise_pulse(rise_b),
      .fall_pulse(fall_b), .evt_pulse(evt_b), .evt_pending(pend_b), .overflow(ovf_b),
      .evt_cnt(cnt_b));

   task automatic tick();
      @(posedge out_clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; async_a = '0; async_b = '0; evt_ack = '0; cnt_clr = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
   endtask

   // Waits (bounded) until the selected evt_pulse is high; caller judges ok.
   task automatic wait_evt(input bit use_b, input int ch, input int max, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < max && !ok; n++) begin
         tick();
         if (use_b ? evt_b[ch] : evt_a[ch]) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; async_a = 4'hF; async_b = 4'hF; evt_ack = '0; cnt_clr = 1'b0;
      edge_mode = 8'hFF;
      tick(); tick(); tick();
      n_tests++;
      if ({level_a, rise_a, fall_a, evt_a, pend_a, ovf_a, cnt_a} !== 56'd0) begin
         n_fail++; $display("FAIL reset_a: got %0h expected 0",
                            {level_a, rise_a, fall_a, evt_a, pend_a, ovf_a, cnt_a});
      end
      n_tests++;
      if ({level_b, rise_b, fall_b, evt_b, pend_b, ovf_b, cnt_b} !== 40'd0) begin
         n_fail++; $display("FAIL reset_b: got %0h expected 0",
                            {level_b, rise_b, fall_b, evt_b, pend_b, ovf_b, cnt_b});
      end
   endtask

   task automatic test_reset_step();
      do_reset();
      edge_mode = 8'h55;
      async_a[2] = 1'b1;
      tick(); tick();
      n_tests++;
      if (rise_a !== 4'b0000) begin
         n_fail++; $display("FAIL step_early: rise=%b expected 0000", rise_a);
      end
      tick();
      n_tests++;
      if ({rise_a, evt_a, pend_a} !== {4'b0100, 4'b0100, 4'b0000}) begin
         n_fail++; $display("FAIL step_pulse: rise=%b evt=%b pend=%b expected 0100 0100 0000",
                            rise_a, evt_a, pend_a);
      end
      tick();
      n_tests++;
      if ({rise_a, pend_a, level_a, cnt_a} !== {4'b0000, 4'b0100, 4'b0100, 32'h0001_0000}) begin
         n_fail++; $display("FAIL step_after: rise=%b pend=%b lvl=%b cnt=%h expected 0000 0100 0100 00010000",
                            rise_a, pend_a, level_a, cnt_a);
      end
   endtask

   task automatic test_filter();
      int nr, nf, ne, ng;
      do_reset();
      edge_mode = 8'h55;
      async_b[0] = 1'b1;
      tick(); tick();
      async_b[0] = 1'b0;
      ng = 0;
      for (int t = 0; t < 10; t++) begin
         tick();
         ng += int'(rise_b[0]) + int'(fall_b[0]) + int'(level_b[0]);
      end
      n_tests++;
      if (ng !== 0) begin
         n_fail++; $display("FAIL filt_glitch: activity=%0d expected 0", ng);
      end
      nr = 0; nf = 0; ne = 0;
      async_b[0] = 1'b1;
      for (int t = 1; t <= 30; t++) begin
         if (t == 11) async_b[0] = 1'b0;
         tick();
         if (t == 5) begin
            n_tests++;
            if (rise_b[0] !== 1'b0) begin
               n_fail++; $display("FAIL filt_lat_early: rise=%b expected 0", rise_b[0]);
            end
         end
         if (t == 6) begin
            n_tests++;
            if (rise_b[0] !== 1'b1) begin
               n_fail++; $display("FAIL filt_lat: rise=%b expected 1", rise_b[0]);
            end
         end
         nr += int'(rise_b[0]); nf += int'(fall_b[0]); ne += int'(evt_b[0]);
      end
      n_tests++;
      if (nr !== 1 || nf !== 1 || ne !== 1 || cnt_b[3:0] !== 4'd1 || level_b[0] !== 1'b0) begin
         n_fail++; $display("FAIL filt_pulse: rise=%0d fall=%0d evt=%0d cnt=%0d lvl=%b expected 1 1 1 1 0",
                            nr, nf, ne, cnt_b[3:0], level_b[0]);
      end
   endtask

   task automatic test_mode_both();
      int ne, nrf;
      for (int m = 0; m < 2; m++) begin
         do_reset();
         edge_mode = (m == 0) ? 8'b0000_1100 : 8'b0000_0000;
         ne = 0; nrf = 0;
         for (int k = 0; k < 5; k++) begin
            async_a[1] = ~async_a[1];
            repeat (4) begin
               tick();
               ne += int'(evt_a[1]); nrf += int'(rise_a[1]) + int'(fall_a[1]);
            end
         end
         repeat (4) begin
            tick();
            ne += int'(evt_a[1]); nrf += int'(rise_a[1]) + int'(fall_a[1]);
         end
         n_tests++;
         if (m == 0 && (ne !== 5 || nrf !== 5 || cnt_a[15:8] !== 8'd5 || pend_a[1] !== 1'b1)) begin
            n_fail++; $display("FAIL mode_both: evt=%0d edges=%0d cnt=%0d pend=%b expected 5 5 5 1",
                               ne, nrf, cnt_a[15:8], pend_a[1]);
         end
         if (m == 1 && (ne !== 0 || nrf !== 5 || cnt_a !== 32'd0 || pend_a !== 4'd0)) begin
            n_fail++; $display("FAIL mode_off: evt=%0d edges=%0d cnt=%h pend=%b expected 0 5 0 0",
                               ne, nrf, cnt_a, pend_a);
         end
      end
   endtask

   task automatic test_handshake();
      bit ok;
      do_reset();
      edge_mode = 8'h55;
      evt_ack = 4'b1000;
      tick();
      evt_ack = '0;
      n_tests++;
      if (pend_a[3] !== 1'b0) begin
         n_fail++; $display("FAIL hs_idle_ack: pend=%b expected 0", pend_a[3]);
      end
      async_a[3] = 1'b1;
      wait_evt(1'b0, 3, 10, ok);
      tick();
      n_tests++;
      if (!ok || pend_a[3] !== 1'b1 || ovf_a[3] !== 1'b0) begin
         n_fail++; $display("FAIL hs_first: seen=%b pend=%b ovf=%b expected 1 1 0", ok, pend_a[3], ovf_a[3]);
      end
      async_a[3] = 1'b0; repeat (4) tick();
      async_a[3] = 1'b1;
      wait_evt(1'b0, 3, 10, ok);
      tick();
      n_tests++;
      if (!ok || ovf_a[3] !== 1'b1 || cnt_a[31:24] !== 8'd2) begin
         n_fail++; $display("FAIL hs_overflow: seen=%b ovf=%b cnt=%0d expected 1 1 2", ok, ovf_a[3], cnt_a[31:24]);
      end
      async_a[3] = 1'b0; repeat (4) tick();
      async_a[3] = 1'b1;
      wait_evt(1'b0, 3, 10, ok);
      evt_ack = 4'b1000;
      tick();
      evt_ack = '0;
      n_tests++;
      if (!ok || pend_a[3] !== 1'b1 || ovf_a[3] !== 1'b1 || cnt_a[31:24] !== 8'd3) begin
         n_fail++; $display("FAIL hs_ack_coinc: seen=%b pend=%b ovf=%b cnt=%0d expected 1 1 1 3",
                            ok, pend_a[3], ovf_a[3], cnt_a[31:24]);
      end
      evt_ack = 4'b1000;
      tick();
      evt_ack = '0;
      n_tests++;
      if (pend_a[3] !== 1'b0 || ovf_a[3] !== 1'b1) begin
         n_fail++; $display("FAIL hs_ack: pend=%b ovf=%b expected 0 1", pend_a[3], ovf_a[3]);
      end
   endtask

   task automatic test_saturation();
      bit ok;
      int ne;
      do_reset();
      edge_mode = 8'b0000_0011;
      ne = 0;
      for (int k = 0; k < 20; k++) begin
         async_b[0] = ~async_b[0];
         repeat (6) begin tick(); ne += int'(evt_b[0]); end
      end
      repeat (6) begin tick(); ne += int'(evt_b[0]); end
      n_tests++;
      if (ne !== 20 || cnt_b[3:0] !== 4'd15 || ovf_b[0] !== 1'b1) begin
         n_fail++; $display("FAIL sat: evt=%0d cnt=%0d ovf=%b expected 20 15 1", ne, cnt_b[3:0], ovf_b[0]);
      end
      async_b[0] = ~async_b[0];
      wait_evt(1'b1, 0, 12, ok);
      cnt_clr = 1'b1; evt_ack = 4'b0001;
      tick();
      cnt_clr = 1'b0; evt_ack = '0;
      n_tests++;
      if (!ok || cnt_b[3:0] !== 4'd1 || ovf_b[0] !== 1'b0 || pend_b[0] !== 1'b1) begin
         n_fail++; $display("FAIL clr_evt: seen=%b cnt=%0d ovf=%b pend=%b expected 1 1 0 1",
                            ok, cnt_b[3:0], ovf_b[0], pend_b[0]);
      end
      async_b[0] = ~async_b[0];
      wait_evt(1'b1, 0, 12, ok);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      n_tests++;
      if (!ok || cnt_b[3:0] !== 4'd1 || ovf_b[0] !== 1'b1) begin
         n_fail++; $display("FAIL clr_vs_ovf: seen=%b cnt=%0d ovf=%b expected 1 1 1", ok, cnt_b[3:0], ovf_b[0]);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int nr;
      do_reset();
      edge_mode = 8'h55;
      async_b[1] = 1'b1;
      wait_evt(1'b1, 1, 12, ok);
      tick();
      n_tests++;
      if (!ok || pend_b[1] !== 1'b1) begin
         n_fail++; $display("FAIL mid_setup: seen=%b pend=%b expected 1 1", ok, pend_b[1]);
      end
      async_b[0] = 1'b1;
      tick(); tick(); tick();
      #3 rst = 1'b0;
      #1;
      n_tests++;
      if ({level_b, rise_b, fall_b, evt_b, pend_b, ovf_b, cnt_b} !== 40'd0) begin
         n_fail++; $display("FAIL mid_reset: got %0h expected 0",
                            {level_b, rise_b, fall_b, evt_b, pend_b, ovf_b, cnt_b});
      end
      tick(); tick();
      rst = 1'b1;
      nr = 0;
      repeat (15) begin tick(); nr += int'(rise_b[0]); end
      n_tests++;
      if (nr !== 1 || pend_b[1:0] !== 2'b11 || cnt_b[3:0] !== 4'd1 || ovf_b !== 4'd0) begin
         n_fail++; $display("FAIL mid_fresh: rises=%0d pend=%b cnt=%0d ovf=%b expected 1 11 1 0000",
                            nr, pend_b[1:0], cnt_b[3:0], ovf_b);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_reset_step();
      test_filter();
      test_mode_both();
      test_handshake();
      test_saturation();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
